// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Connects the core's load/store requests to a word-only data memory. It adds
//   sub-word loads (LB/LBU/LH/LHU) with sign/zero extension, and sub-word
//   stores (SB/SH) by read-modify-write. It also checks alignment, address
//   range and opcode legality. The core sees a Req/Ready/Done handshake.
//
// Ports
//   i_clk               system clock, rising edge
//   i_rst_n             asynchronous active-low reset
//   i_req               access request, accepted when i_req & o_ready at an edge
//   i_is_store          1 = store, 0 = load
//   i_op[2:0]           000 byte, 001 half, 010 word, 100 byte-u, 101 half-u
//   i_addr[31:0]        byte address
//   i_store_data[31:0]  store data (low byte/half used for SB/SH)
//   o_ready             unit idle, can accept
//   o_done              one-cycle completion pulse
//   o_fault             valid with o_done: misaligned, out of range or illegal
//   o_load_data[31:0]   load result, held until the next load completes
//   o_mem_address[31:0] word address to data memory (0 while idle)
//   o_mem_write_data    word to write (0 outside the write cycle)
//   o_mem_write_enable  data memory write strobe, decoded from state only
//   i_mem_read_data     combinational read data from data memory
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_is_store,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_store_data,
    output logic        o_ready,
    output logic        o_done,
    output logic        o_fault,
    output logic [31:0] o_load_data,
    output logic [31:0] o_mem_address,
    output logic [31:0] o_mem_write_data,
    output logic        o_mem_write_enable,
    input  logic [31:0] i_mem_read_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MERGE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [2:0]  r_op;
    logic        r_store;
    logic [31:0] r_addr;
    logic [31:0] r_sdata;
    logic        r_fault;
    logic [31:0] r_merged;
    logic [31:0] r_load_data;

    logic        w_accept;
    logic        w_op_illegal;
    logic        w_misaligned;
    logic        w_out_of_range;
    logic        w_store_unsigned;
    logic        w_fault;
    logic [7:0]  w_byte_lane;
    logic [15:0] w_half_lane;
    logic [31:0] w_load_result;
    logic [31:0] w_merged;

    // ------------------------------------------------------------------------
    // Request decode (evaluated on the raw inputs, used only at accept)
    // ------------------------------------------------------------------------
    assign w_accept         = i_req && (r_state == S_IDLE);
    assign w_op_illegal     = (i_op == 3'b011) || (i_op[2:1] == 2'b11);
    assign w_misaligned     = ((i_op[1:0] == 2'b01) && i_addr[0]) ||
                              ((i_op[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
    assign w_out_of_range   = (i_addr >= 32'(MEM_BYTES));
    // Unsigned variants only make sense for loads.
    assign w_store_unsigned = i_is_store && i_op[2];
    assign w_fault          = w_op_illegal || w_misaligned ||
                              w_out_of_range || w_store_unsigned;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    // NOTE: the default assignment at the top keeps this block latch-free even
    // when a case arm does not assign the output.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_fault)                  w_next_state = S_DONE;
                    else if (!i_is_store)         w_next_state = S_LOAD;
                    else if (i_op[1:0] == 2'b10)  w_next_state = S_WRITE;
                    else                          w_next_state = S_MERGE;
                end
            end
            S_LOAD:  w_next_state = S_DONE;
            S_MERGE: w_next_state = S_WRITE;
            S_WRITE: w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs, decoded from the state register only
    // ------------------------------------------------------------------------
    always_comb begin
        o_ready            = (r_state == S_IDLE);
        o_done             = (r_state == S_DONE);
        o_fault            = (r_state == S_DONE) && r_fault;
        o_mem_write_enable = (r_state == S_WRITE);
        o_mem_address      = (r_state == S_IDLE) ? 32'd0 : {r_addr[31:2], 2'b00};
        o_mem_write_data   = 32'd0;
        if ((r_state == S_WRITE) && r_store) begin
            o_mem_write_data = (r_op[1:0] == 2'b10) ? r_sdata : r_merged;
        end
    end

    assign o_load_data = r_load_data;

    // ------------------------------------------------------------------------
    // Load lane extraction (little-endian: byte n lives at bits [8n+7:8n])
    // ------------------------------------------------------------------------
    always_comb begin
        w_byte_lane = i_mem_read_data[7:0];
        unique case (r_addr[1:0])
            2'd0: w_byte_lane = i_mem_read_data[7:0];
            2'd1: w_byte_lane = i_mem_read_data[15:8];
            2'd2: w_byte_lane = i_mem_read_data[23:16];
            2'd3: w_byte_lane = i_mem_read_data[31:24];
            default: w_byte_lane = i_mem_read_data[7:0];
        endcase
        w_half_lane = r_addr[1] ? i_mem_read_data[31:16] : i_mem_read_data[15:0];

        w_load_result = i_mem_read_data;
        unique case (r_op)
            3'b000:  w_load_result = {{24{w_byte_lane[7]}}, w_byte_lane};
            3'b001:  w_load_result = {{16{w_half_lane[15]}}, w_half_lane};
            3'b100:  w_load_result = {24'd0, w_byte_lane};
            3'b101:  w_load_result = {16'd0, w_half_lane};
            default: w_load_result = i_mem_read_data;
        endcase
    end

    // ------------------------------------------------------------------------
    // Store merge: replace only the addressed lanes, keep the rest bit-exact
    // ------------------------------------------------------------------------
    always_comb begin
        w_merged = i_mem_read_data;
        if (r_op[1:0] == 2'b00) begin
            unique case (r_addr[1:0])
                2'd0: w_merged[7:0]   = r_sdata[7:0];
                2'd1: w_merged[15:8]  = r_sdata[7:0];
                2'd2: w_merged[23:16] = r_sdata[7:0];
                2'd3: w_merged[31:24] = r_sdata[7:0];
                default: w_merged = i_mem_read_data;
            endcase
        end else if (r_addr[1]) begin
            w_merged[31:16] = r_sdata[15:0];
        end else begin
            w_merged[15:0]  = r_sdata[15:0];
        end
    end

    // ------------------------------------------------------------------------
    // Captured request, merge buffer and load result
    // ------------------------------------------------------------------------
    // NOTE: every datapath register is cleared by reset so that a reset in the
    // middle of an access leaves no stale request behind.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op        <= 3'd0;
            r_store     <= 1'b0;
            r_addr      <= 32'd0;
            r_sdata     <= 32'd0;
            r_fault     <= 1'b0;
            r_merged    <= 32'd0;
            r_load_data <= 32'd0;
        end else begin
            if (w_accept) begin
                r_op    <= i_op;
                r_store <= i_is_store;
                r_addr  <= i_addr;
                r_sdata <= i_store_data;
                r_fault <= w_fault;
            end
            if (r_state == S_LOAD) begin
                r_load_data <= w_load_result;
            end
            if (r_state == S_MERGE) begin
                r_merged <= w_merged;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//   Directed bench for load_store_unit. It has a word memory model and a
//   scoreboard queue: the expected outcome is pushed when an access is driven
//   and popped and compared when Done is seen.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        is_store;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic        ready;
    logic        done;
    logic        fault;
    logic [31:0] load_data;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    load_store_unit #(.MEM_BYTES(1024)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_req              (req),
        .i_is_store         (is_store),
        .i_op               (op),
        .i_addr             (addr),
        .i_store_data       (sdata),
        .o_ready            (ready),
        .o_done             (done),
        .o_fault            (fault),
        .o_load_data        (load_data),
        .o_mem_address      (mem_address),
        .o_mem_write_data   (mem_wdata),
        .o_mem_write_enable (mem_we),
        .i_mem_read_data    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory model: 256 words, combinational read, write on rising edge.
    // A bench-side port preloads words.
    logic [31:0] mem [0:255];
    logic        tb_we;
    logic [31:0] tb_waddr;
    logic [31:0] tb_wdata;

    assign mem_rdata = mem[mem_address[9:2]];

    always @(posedge clk) begin
        if (mem_we)     mem[mem_address[9:2]] <= mem_wdata;
        else if (tb_we) mem[tb_waddr[9:2]]    <= tb_wdata;
    end

    typedef struct packed {
        logic        fault;
        logic [31:0] ld;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_ld;
    int          n_checks;
    int          n_fails;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        tb_we    = 1'b1;
        tb_waddr = a;
        tb_wdata = d;
        @(posedge clk);
        @(negedge clk);
        tb_we    = 1'b0;
    endtask

    // Drives one access and checks its latency, its write-strobe count and the
    // scoreboard entry. ld_val is the expected LoadData for a successful load.
    task automatic do_access(input string tag, input logic st, input logic [2:0] o,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic exp_fault, input logic [31:0] ld_val,
                             input int exp_lat, input int exp_we);
        int   cycles;
        int   we_cnt;
        logic got;
        exp_t e;
        @(negedge clk);
        check({tag, "_ready"}, ready, 1'b1);
        req      = 1'b1;
        is_store = st;
        op       = o;
        addr     = a;
        sdata    = d;
        if (!st && !exp_fault) model_ld = ld_val;
        sb_q.push_back('{fault: exp_fault, ld: model_ld});
        @(posedge clk);
        cycles = 0;
        we_cnt = 0;
        got    = 1'b0;
        while (!got && cycles < 8) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) req = 1'b0;
            if (mem_we) we_cnt++;
            if (done) got = 1'b1;
        end
        check({tag, "_done_seen"}, got, 1'b1);
        check({tag, "_latency"}, cycles, exp_lat);
        check({tag, "_we_cycles"}, we_cnt, exp_we);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_fault"}, fault, e.fault);
            check({tag, "_load_data"}, load_data, e.ld);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        model_ld = 32'd0;
        rst_n    = 1'b0;
        req      = 1'b0;
        is_store = 1'b0;
        op       = 3'd0;
        addr     = 32'd0;
        sdata    = 32'd0;
        tb_we    = 1'b0;
        tb_waddr = 32'd0;
        tb_wdata = 32'd0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", ready, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_fault", fault, 1'b0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_address, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;

        // ---- SW then sub-word loads ----
        do_access("sw_20", 1'b1, 3'b010, 32'h20, 32'h8899AABB, 1'b0, 32'd0, 2, 1);
        check("mem_20_sw", mem[8], 32'h8899AABB);
        do_access("lb_23",  1'b0, 3'b000, 32'h23, 32'd0, 1'b0, 32'hFFFFFF88, 2, 0);
        do_access("lbu_23", 1'b0, 3'b100, 32'h23, 32'd0, 1'b0, 32'h00000088, 2, 0);
        do_access("lh_20",  1'b0, 3'b001, 32'h20, 32'd0, 1'b0, 32'hFFFFAABB, 2, 0);
        do_access("lhu_20", 1'b0, 3'b101, 32'h20, 32'd0, 1'b0, 32'h0000AABB, 2, 0);
        do_access("lb_21",  1'b0, 3'b000, 32'h21, 32'd0, 1'b0, 32'hFFFFFFAA, 2, 0);
        do_access("lhu_22", 1'b0, 3'b101, 32'h22, 32'd0, 1'b0, 32'h00008899, 2, 0);
        do_access("lw_20",  1'b0, 3'b010, 32'h20, 32'd0, 1'b0, 32'h8899AABB, 2, 0);

        // ---- sub-word stores (read-modify-write) ----
        preload(32'h40, 32'h11223344);
        do_access("sb_41", 1'b1, 3'b000, 32'h41, 32'hFFFFFFA5, 1'b0, 32'd0, 3, 1);
        check("mem_40_sb", mem[16], 32'h1122A544);
        do_access("sh_42", 1'b1, 3'b001, 32'h42, 32'h1234BEEF, 1'b0, 32'd0, 3, 1);
        check("mem_40_sh", mem[16], 32'hBEEFA544);

        // ---- faults: no write, LoadData unchanged ----
        do_access("flt_lh_21",  1'b0, 3'b001, 32'h21,  32'd0,        1'b1, 32'd0, 1, 0);
        do_access("flt_sw_22",  1'b1, 3'b010, 32'h22,  32'h55555555, 1'b1, 32'd0, 1, 0);
        check("mem_20_after_fault", mem[8], 32'h8899AABB);
        do_access("flt_lw_400", 1'b0, 3'b010, 32'h400, 32'd0,        1'b1, 32'd0, 1, 0);
        do_access("flt_sb_100", 1'b1, 3'b100, 32'h40,  32'h000000CC, 1'b1, 32'd0, 1, 0);
        check("mem_40_after_fault", mem[16], 32'hBEEFA544);
        do_access("flt_op_111", 1'b0, 3'b111, 32'h20,  32'd0,        1'b1, 32'd0, 1, 0);

        // ---- reset in the middle of a SW write cycle ----
        preload(32'h10, 32'h12345678);
        req      = 1'b1;
        is_store = 1'b1;
        op       = 3'b010;
        addr     = 32'h10;
        sdata    = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        check("rmw_we_before_rst", mem_we, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rmw_we_after_rst", mem_we, 1'b0);
        check("rmw_ready", ready, 1'b1);
        check("rmw_done", done, 1'b0);
        check("rmw_fault", fault, 1'b0);
        check("rmw_load_data", load_data, 32'd0);
        model_ld = 32'd0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rmw_mem_10", mem[4], 32'h12345678);

        // ---- Req held high: four back-to-back LW ----
        preload(32'h0, 32'hA0000001);
        preload(32'h4, 32'hB0000002);
        preload(32'h8, 32'hC0000003);
        preload(32'hC, 32'hD0000004);
        for (int n = 0; n < 16; n++) begin
            logic [31:0] word_val;
            exp_t        e;
            if (n != 0) @(negedge clk);
            check($sformatf("b2b_ready_%0d", n), ready, (n >= 12) || (n % 3 == 0));
            check($sformatf("b2b_done_%0d", n), done, (n % 3 == 2) && (n <= 11));
            if (done) begin
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check($sformatf("b2b_fault_%0d", n), fault, e.fault);
                    check($sformatf("b2b_ld_%0d", n), load_data, e.ld);
                end else begin
                    check($sformatf("b2b_extra_done_%0d", n), 1'b1, 1'b0);
                end
            end
            if (n % 3 == 0 && n < 12) begin
                unique case (n / 3)
                    0: word_val = 32'hA0000001;
                    1: word_val = 32'hB0000002;
                    2: word_val = 32'hC0000003;
                    default: word_val = 32'hD0000004;
                endcase
                req      = 1'b1;
                is_store = 1'b0;
                op       = 3'b010;
                addr     = 32'(n / 3 * 4);
                model_ld = word_val;
                sb_q.push_back('{fault: 1'b0, ld: word_val});
            end
            if (n == 10) req = 1'b0;
        end
        check("b2b_queue_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
